in_service_control: RTL and testbench

- Sequential owner of the 8259A in-service register (ISR) and the priority-rotation state.
- Sets ISR bits on interrupt acknowledge.
- Clears ISR bits on OCW2 EOI commands and on automatic EOI (AEOI).
- Drives the combinational next-ISR value and the rotation value into the highest-level-in-service stage, and consumes that stage's one-hot result for non-specific EOI.

---
 rtl/in_service_control_if.sv | 31 +++
 rtl/in_service_control.sv | 109 ++++++++++
 tb/tb_in_service_control.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/in_service_control_if.sv
// Signal bundle between the 8259A acknowledge/OCW2 front end and the in-service register owner.
// Strobes (ack_first, ack_last, ocw2_valid) are single-cycle pulses with no back-pressure: they act on the rising edge where they are high.
interface in_service_control_if;
  logic [7:0] interrupt;
  logic       ack_first;
  logic       ack_last;
  logic       auto_eoi_config;
  logic       ocw2_valid;
  logic [7:0] ocw2;
  logic [7:0] highest_level_in_service;
  logic [7:0] next_in_service_register;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic       rotate_in_aeoi;
  logic [2:0] acknowledged_level;
  logic       ack_state;

  modport master (
    output interrupt, ack_first, ack_last, auto_eoi_config, ocw2_valid, ocw2,
           highest_level_in_service,
    input  next_in_service_register, in_service_register, priority_rotate,
           rotate_in_aeoi, acknowledged_level, ack_state
  );

  modport slave (
    input  interrupt, ack_first, ack_last, auto_eoi_config, ocw2_valid, ocw2,
           highest_level_in_service,
    output next_in_service_register, in_service_register, priority_rotate,
           rotate_in_aeoi, acknowledged_level, ack_state
  );
endinterface

// File: rtl/in_service_control.sv
// 8259A in-service register and priority-rotation owner: sets ISR bits on acknowledge,
// clears them on OCW2 EOI commands and automatic EOI.
module in_service_control #(
  parameter int       ISR_WIDTH    = 8,
  parameter bit [2:0] ROTATE_RESET = 3'd7
) (
  input logic            clock,
  input logic            reset_n,
  in_service_control_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, IN_ACK = 1'b1} state_t;

  state_t               state, state_next;
  logic [ISR_WIDTH-1:0] isr, set_mask, clear_mask, next_isr;
  logic [2:0]           rotate, rotate_next;
  logic [2:0]           ack_level, ack_level_next, aeoi_level;
  logic                 aeoi_flag, aeoi_flag_next;
  logic                 do_aeoi;
  logic [2:0]           cmd;
  logic [2:0]           cmd_level;
  logic                 ocw2_unused;

  function automatic logic [2:0] encode(input logic [ISR_WIDTH-1:0] v);
    encode = 3'd0;
    for (int i = ISR_WIDTH - 1; i >= 0; i--)
      if (v[i]) encode = 3'(i);
  endfunction

  assign cmd         = bus.ocw2[7:5];
  assign cmd_level   = bus.ocw2[2:0];
  assign ocw2_unused = ^bus.ocw2[4:3];

  always_comb begin
    set_mask       = '0;
    clear_mask     = '0;
    state_next     = state;
    ack_level_next = ack_level;
    rotate_next    = rotate;
    aeoi_flag_next = aeoi_flag;
    aeoi_level     = ack_level;
    do_aeoi        = 1'b0;

    // A first INTA always starts a fresh sequence, even as a restart from IN_ACK.
    if (bus.ack_first) begin
      set_mask       = bus.interrupt;
      ack_level_next = encode(bus.interrupt);
      aeoi_level     = encode(bus.interrupt);
      state_next     = IN_ACK;
      do_aeoi        = bus.ack_last;
    end else if (state == IN_ACK) begin
      do_aeoi = bus.ack_last;
    end

    if (do_aeoi) begin
      state_next = IDLE;
      if (bus.auto_eoi_config) begin
        clear_mask = clear_mask | (ISR_WIDTH'(1) << aeoi_level);
        if (aeoi_flag) rotate_next = aeoi_level;
      end
    end

    // OCW2 rotation is evaluated last so it overrides an AEOI rotation in the same cycle.
    if (bus.ocw2_valid) begin
      case (cmd)
        3'b001: clear_mask = clear_mask | bus.highest_level_in_service;
        3'b011: clear_mask = clear_mask | (ISR_WIDTH'(1) << cmd_level);
        3'b101: begin
          if (bus.highest_level_in_service != '0) begin
            clear_mask  = clear_mask | bus.highest_level_in_service;
            rotate_next = encode(bus.highest_level_in_service);
          end
        end
        3'b111: begin
          clear_mask  = clear_mask | (ISR_WIDTH'(1) << cmd_level);
          rotate_next = cmd_level;
        end
        3'b110:  rotate_next    = cmd_level;
        3'b100:  aeoi_flag_next = 1'b1;
        3'b000:  aeoi_flag_next = 1'b0;
        default: ;
      endcase
    end

    next_isr = (isr | set_mask) & ~clear_mask;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      isr       <= '0;
      rotate    <= ROTATE_RESET;
      aeoi_flag <= 1'b0;
      ack_level <= 3'd0;
    end else begin
      state     <= state_next;
      isr       <= next_isr;
      rotate    <= rotate_next;
      aeoi_flag <= aeoi_flag_next;
      ack_level <= ack_level_next;
    end
  end

  assign bus.next_in_service_register = next_isr;
  assign bus.in_service_register      = isr;
  assign bus.priority_rotate          = rotate;
  assign bus.rotate_in_aeoi           = aeoi_flag;
  assign bus.acknowledged_level       = ack_level;
  assign bus.ack_state                = state;
endmodule

// File: tb/tb_in_service_control.sv
// Directed plus randomized bench for in_service_control against a bit-array reference model.
module tb_in_service_control;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  in_service_control_if bus();
  in_service_control dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  bit m_isr[8];
  int m_rot, m_ack;
  bit m_flag, m_in_ack, m_cfg;

  function automatic logic [7:0] pack_isr();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_isr[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_isr[i] = 1'b0;
    m_rot = 7; m_ack = 0; m_flag = 0; m_in_ack = 0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] exp_isr);
    check({tag, ".isr"},  bus.in_service_register, exp_isr);
    check({tag, ".rot"},  {5'd0, bus.priority_rotate}, 8'(m_rot));
    check({tag, ".flag"}, {7'd0, bus.rotate_in_aeoi}, {7'd0, m_flag});
    check({tag, ".lvl"},  {5'd0, bus.acknowledged_level}, 8'(m_ack));
    check({tag, ".fsm"},  {7'd0, bus.ack_state}, {7'd0, m_in_ack});
  endtask

  task automatic idle_inputs();
    bus.interrupt = '0; bus.ack_first = 0; bus.ack_last = 0;
    bus.ocw2_valid = 0; bus.ocw2 = '0; bus.highest_level_in_service = '0;
    bus.auto_eoi_config = m_cfg;
  endtask

  // One clock of stimulus; the upstream highest-level stage is emulated from the model ISR.
  task automatic apply(input bit af, input bit al, input logic [7:0] irq,
                       input bit ov, input logic [7:0] cmd, input string tag);
    int hi, lvl, aeoi_lvl, new_rot, new_ack, idx, lv;
    bit new_flag, new_in_ack, r, sl, e;
    bit set_b[8], clr_b[8];
    logic [7:0] exp_next;
    @(negedge clock);
    hi = -1;
    for (int k = 1; k <= 8; k++) begin
      idx = (m_rot + k) % 8;
      if (hi < 0 && m_isr[idx]) hi = idx;
    end
    lvl = 0;
    for (int i = 7; i >= 0; i--) if (irq[i]) lvl = i;
    for (int i = 0; i < 8; i++) begin set_b[i] = 0; clr_b[i] = 0; end
    new_rot = m_rot; new_ack = m_ack; new_flag = m_flag; new_in_ack = m_in_ack;
    if (af) begin
      for (int i = 0; i < 8; i++) if (irq[i]) set_b[i] = 1;
      new_ack = lvl; new_in_ack = 1;
    end
    aeoi_lvl = af ? lvl : m_ack;
    if (al && (af || m_in_ack)) begin
      new_in_ack = 0;
      if (m_cfg) begin
        clr_b[aeoi_lvl] = 1;
        if (m_flag) new_rot = aeoi_lvl;
      end
    end
    if (ov) begin
      r = cmd[7]; sl = cmd[6]; e = cmd[5]; lv = int'(cmd[2:0]);
      if (e && !sl && hi >= 0) begin clr_b[hi] = 1; if (r) new_rot = hi; end
      if (e && sl) begin clr_b[lv] = 1; if (r) new_rot = lv; end
      if (!e && sl && r) new_rot = lv;
      if (!e && !sl) new_flag = r;
    end
    for (int i = 0; i < 8; i++) exp_next[i] = (m_isr[i] | set_b[i]) & ~clr_b[i];

    bus.interrupt = irq; bus.ack_first = af; bus.ack_last = al;
    bus.ocw2_valid = ov; bus.ocw2 = cmd; bus.auto_eoi_config = m_cfg;
    bus.highest_level_in_service = (hi < 0) ? 8'h00 : 8'(1 << hi);
    #1;
    check({tag, ".next"}, bus.next_in_service_register, exp_next);
    exp_q.push_back(exp_next);
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) m_isr[i] = exp_next[i];
    m_rot = new_rot; m_ack = new_ack; m_flag = new_flag; m_in_ack = new_in_ack;
    check_state(tag, exp_q.pop_front());
    idle_inputs();
  endtask

  task automatic ack(input logic [7:0] irq, input string tag);
    apply(1, 0, irq, 0, 8'h00, {tag, ".af"});
    apply(0, 1, 8'h00, 0, 8'h00, {tag, ".al"});
  endtask

  task automatic ocw(input logic [7:0] cmd, input string tag);
    apply(0, 0, 8'h00, 1, cmd, tag);
  endtask

  initial begin
    logic [7:0] irq;
    m_cfg = 0;
    model_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    check_state("reset", 8'h00);
    @(negedge clock) reset_n = 1;

    // Reset in the middle of an acknowledge abandons it; the later ack_last is ignored.
    apply(1, 0, 8'h08, 0, 8'h00, "rst_mid.af");
    @(negedge clock) reset_n = 0;
    #1;
    model_reset();
    check_state("rst_mid.async", 8'h00);
    @(negedge clock) reset_n = 1;
    apply(0, 1, 8'h00, 0, 8'h00, "rst_mid.al_ignored");
    check("rst_mid.isr0", bus.in_service_register, 8'h00);

    ack(8'h08, "ack3");
    check("ack3.isr", bus.in_service_register, 8'h08);
    check("ack3.lvl", {5'd0, bus.acknowledged_level}, 8'd3);
    ocw(8'h20, "ns_eoi");
    check("ns_eoi.isr", bus.in_service_register, 8'h00);

    ack(8'h20, "nest5");
    ack(8'h02, "nest1");
    check("nest.isr", bus.in_service_register, 8'h22);
    ocw(8'h65, "sp_eoi5");
    check("sp_eoi5.isr", bus.in_service_register, 8'h02);
    ocw(8'h61, "sp_eoi1");

    ocw(8'h80, "aeoi_rot_on");
    check("aeoi_rot_on.flag", {7'd0, bus.rotate_in_aeoi}, 8'd1);
    m_cfg = 1;
    apply(1, 0, 8'h40, 0, 8'h00, "aeoi.af");
    check("aeoi.mid_isr", bus.in_service_register, 8'h40);
    apply(0, 1, 8'h00, 0, 8'h00, "aeoi.al");
    check("aeoi.isr", bus.in_service_register, 8'h00);
    check("aeoi.rot", {5'd0, bus.priority_rotate}, 8'd6);
    apply(1, 1, 8'h10, 0, 8'h00, "aeoi.same_cycle");
    check("aeoi.same_isr", bus.in_service_register, 8'h00);
    m_cfg = 0;
    ocw(8'h00, "aeoi_rot_off");

    ocw(8'hC3, "setprio3");
    ack(8'h01, "rot.ack0");
    ack(8'h10, "rot.ack4");
    check("rot.isr11", bus.in_service_register, 8'h11);
    ocw(8'hA0, "rot_ns");
    check("rot_ns.isr", bus.in_service_register, 8'h01);
    check("rot_ns.rot", {5'd0, bus.priority_rotate}, 8'd4);
    ocw(8'h60, "clr0");
    ocw(8'hA0, "rot_ns_empty");
    check("rot_ns_empty.rot", {5'd0, bus.priority_rotate}, 8'd4);

    apply(1, 0, 8'h04, 1, 8'h62, "coll.clr_wins");
    check("coll.bit2", bus.in_service_register, 8'h00);
    apply(1, 0, 8'h04, 1, 8'h61, "coll.diff_bits");
    check("coll.isr04", bus.in_service_register, 8'h04);
    apply(0, 1, 8'h00, 0, 8'h00, "coll.al");
    ocw(8'hC2, "setprio2");
    check("setprio2.rot", {5'd0, bus.priority_rotate}, 8'd2);
    check("setprio2.isr", bus.in_service_register, 8'h04);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) m_cfg = ~m_cfg;
      case ($urandom_range(0, 2))
        0:       irq = 8'h00;
        1:       irq = 8'(1 << $urandom_range(0, 7));
        default: irq = 8'($urandom);
      endcase
      apply($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, irq,
            $urandom_range(0, 2) == 0, 8'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
